// File: rtl/aes_decipher_block_p.sv
`default_nettype none
// =============================================================================
// Module   : aes_decipher_block_p
// Purpose  : Iterative AES-128/192/256 inverse cipher with configurable S-box lanes.
// Revision : 1.0
// =============================================================================
module aes_decipher_block_p #(
   parameter int SBOX_LANES = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         next,
   input  logic         abort,
   input  logic [1:0]   keylen,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   input  logic [127:0] block,
   output logic [127:0] new_block,
   output logic         ready,
   output logic         valid,
   output logic         error
);
   localparam int         SBOX_CYCLES = 4 / SBOX_LANES;
   localparam logic [1:0] CTR_LAST    = 2'(SBOX_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_INIT = 2'd1;
   localparam logic [1:0] ST_SBOX = 2'd2;
   localparam logic [1:0] ST_MAIN = 2'd3;

   generate
      if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
         $error("SBOX_LANES must be 1, 2 or 4");
      end
   endgenerate

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse affine transform followed by the GF(2^8) inverse computed as x^254.
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] a;
      logic [7:0] sq;
      logic [7:0] r;
      a  = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
      return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] b);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 32*c - 8*r -: 8] = b[127 - 32*((c - r + 4) % 4) - 8*r -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] b);
      logic [127:0] o;
      logic [7:0]   s0, s1, s2, s3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         s0 = b[127 - 32*c      -: 8];
         s1 = b[127 - 32*c -  8 -: 8];
         s2 = b[127 - 32*c - 16 -: 8];
         s3 = b[127 - 32*c - 24 -: 8];
         o[127 - 32*c -: 32] = {
            gf_mul(s0, 8'h0e) ^ gf_mul(s1, 8'h0b) ^ gf_mul(s2, 8'h0d) ^ gf_mul(s3, 8'h09),
            gf_mul(s0, 8'h09) ^ gf_mul(s1, 8'h0e) ^ gf_mul(s2, 8'h0b) ^ gf_mul(s3, 8'h0d),
            gf_mul(s0, 8'h0d) ^ gf_mul(s1, 8'h09) ^ gf_mul(s2, 8'h0e) ^ gf_mul(s3, 8'h0b),
            gf_mul(s0, 8'h0b) ^ gf_mul(s1, 8'h0d) ^ gf_mul(s2, 8'h09) ^ gf_mul(s3, 8'h0e)};
      end
      return o;
   endfunction

   logic [1:0]   state_q, state_d;
   logic [3:0]   round_q, round_d;
   logic [1:0]   ctr_q, ctr_d;
   logic [127:0] block_q, block_d;
   logic         ready_q, ready_d;
   logic         valid_q, valid_d;
   logic         error_q, error_d;
   logic [3:0]   w_nr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (next && !abort && keylen != 2'b11) state_d = ST_INIT;
         ST_INIT: state_d = ST_SBOX;
         ST_SBOX: if (ctr_q == CTR_LAST) state_d = ST_MAIN;
         ST_MAIN: state_d = (round_q == 4'd0) ? ST_IDLE : ST_SBOX;
         default: state_d = ST_IDLE;
      endcase
      if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
   end

   always_comb begin
      round_d = round_q;
      ctr_d   = ctr_q;
      block_d = block_q;
      ready_d = ready_q;
      valid_d = 1'b0;
      error_d = 1'b0;
      case (keylen)
         2'b00:   w_nr = 4'd10;
         2'b01:   w_nr = 4'd12;
         default: w_nr = 4'd14;
      endcase
      case (state_q)
         ST_IDLE: begin
            if (next && !abort) begin
               if (keylen == 2'b11) begin
                  error_d = 1'b1;
               end else begin
                  round_d = w_nr;
                  ready_d = 1'b0;
               end
            end
         end
         ST_INIT: begin
            block_d = inv_shift_rows(block ^ round_key);
            ctr_d   = 2'd0;
         end
         ST_SBOX: begin
            for (int l = 0; l < SBOX_LANES; l++) begin
               block_d[127 - 32*(int'(ctr_q)*SBOX_LANES + l) -: 32] =
                  inv_sub_word(block_q[127 - 32*(int'(ctr_q)*SBOX_LANES + l) -: 32]);
            end
            ctr_d = ctr_q + 2'd1;
            if (ctr_q == CTR_LAST && round_q != 4'd0) round_d = round_q - 4'd1;
         end
         default: begin
            ctr_d = 2'd0;
            if (round_q != 4'd0) begin
               block_d = inv_shift_rows(inv_mix_columns(block_q ^ round_key));
            end else begin
               block_d = block_q ^ round_key;
               ready_d = 1'b1;
               valid_d = 1'b1;
            end
         end
      endcase
      // Cancellation leaves the partial block visible but clears sequencing state.
      if (abort && state_q != ST_IDLE) begin
         round_d = 4'd0;
         ctr_d   = 2'd0;
         block_d = block_q;
         ready_d = 1'b1;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         round_q <= 4'd0;
         ctr_q   <= 2'd0;
         block_q <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         round_q <= round_d;
         ctr_q   <= ctr_d;
         block_q <= block_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   assign round     = round_q;
   assign new_block = block_q;
   assign ready     = ready_q;
   assign valid     = valid_q;
   assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_decipher_block_p.sv
`default_nettype none
// =============================================================================
// Module   : tb_aes_decipher_block_p
// Purpose  : FIPS-197 vector checks of the decipher block for 1, 2 and 4 lanes.
// Revision : 1.0
// =============================================================================
module tb_aes_decipher_block_p;
   localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              abort;
   logic [1:0]        keylen;
   logic [127:0]      block;
   logic [2:0]        next_v, ready_v, valid_v, error_v;
   logic [2:0][3:0]   rnd_v;
   logic [2:0][127:0] rk_v, nb_v;
   logic [127:0]      rk_tab [0:14];
   logic [127:0]      sb_q [$];
   int                total = 0;
   int                bad = 0;

   always #5 clk = ~clk;

   assign rk_v[0] = rk_tab[rnd_v[0]];
   assign rk_v[1] = rk_tab[rnd_v[1]];
   assign rk_v[2] = rk_tab[rnd_v[2]];

   aes_decipher_block_p #(.SBOX_LANES(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .next(next_v[0]), .abort(abort), .keylen(keylen),
      .round(rnd_v[0]), .round_key(rk_v[0]), .block(block), .new_block(nb_v[0]),
      .ready(ready_v[0]), .valid(valid_v[0]), .error(error_v[0]));
   aes_decipher_block_p #(.SBOX_LANES(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .next(next_v[1]), .abort(abort), .keylen(keylen),
      .round(rnd_v[1]), .round_key(rk_v[1]), .block(block), .new_block(nb_v[1]),
      .ready(ready_v[1]), .valid(valid_v[1]), .error(error_v[1]));
   aes_decipher_block_p #(.SBOX_LANES(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .next(next_v[2]), .abort(abort), .keylen(keylen),
      .round(rnd_v[2]), .round_key(rk_v[2]), .block(block), .new_block(nb_v[2]),
      .ready(ready_v[2]), .valid(valid_v[2]), .error(error_v[2]));

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box: multiplicative inverse found by search, then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] y;
      y = 8'h00;
      for (int k = 1; k < 256; k++) if (gm(x, 8'(k)) == 8'h01) y = 8'(k);
      return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Key bytes are 00,01,02,... as in the FIPS-197 appendix C vectors.
   task automatic expand(input logic [1:0] kl);
      int          nk, nr;
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      nk = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
      nr = nk + 6;
      for (int i = 0; i < 60; i++) w[i] = 32'h0;
      for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      rc = 8'h01;
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 15; r++)
         rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
   endtask

   task automatic run(input int d, input logic [1:0] kl, input logic [127:0] blk,
                      input logic [127:0] pt, input int exp_lat, input bit hold, input string tag);
      int           n;
      int           vc;
      logic [127:0] e;
      expand(kl);
      sb_q.push_back(pt);
      keylen    = kl;
      block     = blk;
      next_v[d] = 1'b1;
      n  = 0;
      vc = 0;
      while (n < 300) begin
         @(negedge clk);
         n++;
         if (!hold) next_v[d] = 1'b0;
         if (n == 1) check({tag, "_busy"}, 128'(ready_v[d]), 128'd0);
         if (valid_v[d]) begin
            vc++;
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
            check({tag, "_plaintext"}, nb_v[d], e);
         end
         if (ready_v[d] && n > 1) break;
      end
      check({tag, "_latency"}, 128'(n), 128'(exp_lat));
      check({tag, "_valid_count"}, 128'(vc), 128'd1);
   endtask

   initial begin
      int vc;
      reset_n = 1'b0;
      abort   = 1'b0;
      keylen  = 2'b00;
      block   = '0;
      next_v  = 3'b000;
      for (int r = 0; r < 15; r++) rk_tab[r] = '0;
      repeat (2) @(negedge clk);
      check("rst_ready",  128'(ready_v), 128'h7);
      check("rst_round",  128'(rnd_v[0]), 128'd0);
      check("rst_block",  nb_v[0], 128'd0);
      check("rst_valid",  128'(valid_v), 128'd0);
      check("rst_error",  128'(error_v), 128'd0);
      reset_n = 1'b1;
      @(negedge clk);

      run(0, 2'b00, C128, PT, 52, 1'b0, "aes128_l1");
      run(0, 2'b01, C192, PT, 62, 1'b0, "aes192_l1");
      run(0, 2'b10, C256, PT, 72, 1'b0, "aes256_l1");
      run(1, 2'b00, C128, PT, 32, 1'b0, "aes128_l2");
      run(2, 2'b00, C128, PT, 22, 1'b0, "aes128_l4");

      // Reserved key length is rejected with a single error pulse.
      keylen    = 2'b11;
      next_v[0] = 1'b1;
      @(negedge clk);
      next_v[0] = 1'b0;
      check("rsv_error",  128'(error_v[0]), 128'd1);
      check("rsv_ready",  128'(ready_v[0]), 128'd1);
      check("rsv_round",  128'(rnd_v[0]), 128'd0);
      check("rsv_valid",  128'(valid_v[0]), 128'd0);
      check("rsv_block",  nb_v[0], PT);
      @(negedge clk);
      check("rsv_error_end", 128'(error_v[0]), 128'd0);

      // Abort together with next in IDLE starts nothing.
      keylen    = 2'b00;
      abort     = 1'b1;
      next_v[0] = 1'b1;
      @(negedge clk);
      abort     = 1'b0;
      next_v[0] = 1'b0;
      check("abidle_ready", 128'(ready_v[0]), 128'd1);
      check("abidle_error", 128'(error_v[0]), 128'd0);
      check("abidle_round", 128'(rnd_v[0]), 128'd0);

      // Abort 20 cycles into an AES-256 run.
      expand(2'b10);
      keylen    = 2'b10;
      block     = C256;
      next_v[0] = 1'b1;
      vc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         next_v[0] = 1'b0;
         if (valid_v[0]) vc++;
      end
      check("abort_busy", 128'(ready_v[0]), 128'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_ready", 128'(ready_v[0]), 128'd1);
      check("abort_round", 128'(rnd_v[0]), 128'd0);
      for (int i = 0; i < 4; i++) begin
         if (valid_v[0]) vc++;
         @(negedge clk);
      end
      check("abort_no_valid", 128'(vc), 128'd0);
      check("abort_idle",     128'(ready_v[0]), 128'd1);
      run(0, 2'b00, C128, PT, 52, 1'b0, "after_abort");

      // Asynchronous reset during the SBOX phase.
      expand(2'b00);
      keylen    = 2'b00;
      block     = C128;
      next_v[0] = 1'b1;
      @(negedge clk);
      next_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 128'(ready_v[0]), 128'd0);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_block", nb_v[0], 128'd0);
      check("async_rst_ready", 128'(ready_v[0]), 128'd1);
      check("async_rst_round", 128'(rnd_v[0]), 128'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Back-to-back starts with next held high throughout.
      run(0, 2'b00, C128, PT, 52, 1'b1, "b2b_first");
      run(0, 2'b00, C128, PT, 52, 1'b1, "b2b_second");
      next_v[0] = 1'b0;
      @(negedge clk);
      check("sb_drained", 128'(sb_q.size()), 128'd0);
      check("final_idle", 128'(ready_v[0]), 128'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
